// File: rtl/riscv_defines.sv
// Shared ALU opcodes, vector modes, issue-FSM state and the request entry
// carried through the issue FIFO.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 7'b0010101;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

  // Widest tag an entry can carry; the issue block's TAG_W must not exceed it.
  localparam int TAG_MAX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    logic [31:0]             a;
    logic [31:0]             b;
    logic [31:0]             c;
    logic [1:0]              vec_mode;
    logic [TAG_MAX_W-1:0]    tag;
  } alu_req_t;

endpackage

// File: rtl/riscv_alu_issue_fifo.sv
// Request FIFO with wrapping pointers (one extra MSB distinguishes full from
// empty); flush empties it and overrides any push/pop in the same cycle.
module riscv_alu_issue_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       data_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  T            r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push = push_i && !full_o  && !flush_i;
  assign w_pop  = pop_i  && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rptr[AW-1:0]];
  assign full_o  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign empty_o = (r_wptr == r_rptr);
  assign count_o = r_wptr - r_rptr;

endmodule

// File: rtl/riscv_alu_issue.sv
// ALU issue stage: queues decoded requests, presents the head to the ALU and
// captures the result into a writeback register with its destination tag.
module riscv_alu_issue
  import riscv_defines::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] req_operator_i,
  input  logic [31:0]             req_operand_a_i,
  input  logic [31:0]             req_operand_b_i,
  input  logic [31:0]             req_operand_c_i,
  input  logic [1:0]              req_vector_mode_i,
  input  logic [TAG_W-1:0]        req_tag_i,
  output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
  output logic [31:0]             alu_operand_a_o,
  output logic [31:0]             alu_operand_b_o,
  output logic [31:0]             alu_operand_c_o,
  output logic [1:0]              alu_vector_mode_o,
  input  logic                    alu_ready_i,
  input  logic [31:0]             alu_result_i,
  input  logic                    alu_comparison_i,
  output logic                    alu_ex_ready_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [31:0]             wb_result_o,
  output logic                    wb_cmp_o,
  output logic [TAG_W-1:0]        wb_tag_o,
  output logic                    busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e    r_state;
  issue_state_e    w_state_nxt;
  alu_req_t        w_req;
  alu_req_t        w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_capture;
  logic            w_more;
  logic            r_wb_valid;
  logic [31:0]     r_wb_result;
  logic            r_wb_cmp;
  logic [TAG_W-1:0] r_wb_tag;

  always_comb begin
    w_req              = '0;
    w_req.op           = req_operator_i;
    w_req.a            = req_operand_a_i;
    w_req.b            = req_operand_b_i;
    w_req.c            = req_operand_c_i;
    w_req.vec_mode     = req_vector_mode_i;
    w_req.tag[TAG_W-1:0] = req_tag_i;
  end

  assign req_ready_o    = !w_full;
  assign w_push         = req_valid_i && !w_full && !flush_i;
  assign alu_ex_ready_o = !r_wb_valid || wb_ready_i;
  assign w_capture      = (r_state == ISSUE) && alu_ready_i && alu_ex_ready_o;

  riscv_alu_issue_fifo #(.DEPTH(DEPTH), .T(alu_req_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_capture),
    .data_i  (w_req),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Look ahead at this cycle's push so a fresh request issues the next cycle.
  assign w_more = (w_count > CW'(1)) || w_push;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty || w_push) w_state_nxt = ISSUE;
      ISSUE:   if (w_capture)          w_state_nxt = w_more ? ISSUE : IDLE;
               else if (alu_ready_i)   w_state_nxt = HOLD;
      HOLD:    if (alu_ex_ready_o)     w_state_nxt = ISSUE;
      default:                         w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    alu_operator_o    = ALU_ADD;
    alu_operand_a_o   = '0;
    alu_operand_b_o   = '0;
    alu_operand_c_o   = '0;
    alu_vector_mode_o = VEC_MODE32;
    if (r_state != IDLE) begin
      alu_operator_o    = w_head.op;
      alu_operand_a_o   = w_head.a;
      alu_operand_b_o   = w_head.b;
      alu_operand_c_o   = w_head.c;
      alu_vector_mode_o = w_head.vec_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_wb_cmp    <= 1'b0;
      r_wb_tag    <= '0;
    end else if (flush_i) begin
      r_wb_valid <= 1'b0;
    end else if (w_capture) begin
      r_wb_valid  <= 1'b1;
      r_wb_result <= alu_result_i;
      r_wb_cmp    <= alu_comparison_i;
      r_wb_tag    <= w_head.tag[TAG_W-1:0];
    end else if (wb_ready_i) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid_o  = r_wb_valid;
  assign wb_result_o = r_wb_result;
  assign wb_cmp_o    = r_wb_cmp;
  assign wb_tag_o    = r_wb_tag;
  assign busy_o      = !w_empty || (r_state != IDLE) || r_wb_valid;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Scoreboard bench for riscv_alu_issue: directed requests push expected
// writebacks; a negedge monitor pops and compares on every wb handshake.
module tb_riscv_alu_issue;
  import riscv_defines::*;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush_i = 1'b0;
  logic                    req_valid_i = 1'b0;
  logic                    req_ready_o;
  logic [ALU_OP_WIDTH-1:0] req_operator_i = ALU_ADD;
  logic [31:0]             req_operand_a_i = '0;
  logic [31:0]             req_operand_b_i = '0;
  logic [31:0]             req_operand_c_i = '0;
  logic [1:0]              req_vector_mode_i = VEC_MODE32;
  logic [TAG_W-1:0]        req_tag_i = '0;
  logic [ALU_OP_WIDTH-1:0] alu_operator_o;
  logic [31:0]             alu_operand_a_o;
  logic [31:0]             alu_operand_b_o;
  logic [31:0]             alu_operand_c_o;
  logic [1:0]              alu_vector_mode_o;
  logic                    alu_ready_i = 1'b0;
  logic [31:0]             alu_result_i;
  logic                    alu_comparison_i;
  logic                    alu_ex_ready_o;
  logic                    wb_valid_o;
  logic                    wb_ready_i = 1'b0;
  logic [31:0]             wb_result_o;
  logic                    wb_cmp_o;
  logic [TAG_W-1:0]        wb_tag_o;
  logic                    busy_o;

  riscv_alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_operator_i),
    .req_operand_a_i   (req_operand_a_i),
    .req_operand_b_i   (req_operand_b_i),
    .req_operand_c_i   (req_operand_c_i),
    .req_vector_mode_i (req_vector_mode_i),
    .req_tag_i         (req_tag_i),
    .alu_operator_o    (alu_operator_o),
    .alu_operand_a_o   (alu_operand_a_o),
    .alu_operand_b_o   (alu_operand_b_o),
    .alu_operand_c_o   (alu_operand_c_o),
    .alu_vector_mode_o (alu_vector_mode_o),
    .alu_ready_i       (alu_ready_i),
    .alu_result_i      (alu_result_i),
    .alu_comparison_i  (alu_comparison_i),
    .alu_ex_ready_o    (alu_ex_ready_o),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_result_o       (wb_result_o),
    .wb_cmp_o          (wb_cmp_o),
    .wb_tag_o          (wb_tag_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: add/sub with an equality flag.
  assign alu_result_i     = (alu_operator_o == ALU_SUB) ? alu_operand_a_o - alu_operand_b_o
                                                        : alu_operand_a_o + alu_operand_b_o;
  assign alu_comparison_i = (alu_operand_a_o == alu_operand_b_o);

  typedef struct packed {
    logic [31:0]      res;
    logic             cmp;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   stream_on = 1'b0;
  int   stream_seen = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got tag %0h result %0h expected no writeback", wb_tag_o, wb_result_o);
      end else begin
        m_e = exp_q.pop_front();
        chk("wb_result", wb_result_o, m_e.res);
        chk("wb_cmp", wb_cmp_o, m_e.cmp);
        chk("wb_tag", wb_tag_o, m_e.tag);
        if (stream_on) begin
          if (stream_seen > 0) chk("wb_consecutive", cyc, last_cyc + 1);
          stream_seen++;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] vm, input logic [TAG_W-1:0] tag, input bit track,
                      input logic [31:0] res, input logic cmp);
    int  n = 0;
    bit  ok = 1'b1;
    req_valid_i       = 1'b1;
    req_operator_i    = op;
    req_operand_a_i   = a;
    req_operand_b_i   = b;
    req_operand_c_i   = 32'hC0DE_0000 | 32'(tag);
    req_vector_mode_i = vm;
    req_tag_i         = tag;
    while (1) begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got req_ready_o=0 for 50 cycles expected 1");
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    if (track && ok) exp_q.push_back('{res: res, cmp: cmp, tag: tag});
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_wb_valid"}, wb_valid_o, 0);
    chk({pfx, "_wb_result"}, wb_result_o, 0);
    chk({pfx, "_wb_cmp"}, wb_cmp_o, 0);
    chk({pfx, "_wb_tag"}, wb_tag_o, 0);
    chk({pfx, "_req_ready"}, req_ready_o, 1);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_alu_op"}, alu_operator_o, ALU_ADD);
    chk({pfx, "_alu_a"}, alu_operand_a_o, 0);
    chk({pfx, "_alu_b"}, alu_operand_b_o, 0);
    chk({pfx, "_alu_vm"}, alu_vector_mode_o, VEC_MODE32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    alu_ready_i = 1'b1;
    wb_ready_i  = 1'b1;

    // single op: 5+7, two-cycle latency
    send(ALU_ADD, 32'd5, 32'd7, VEC_MODE32, 4'h3, 1'b1, 32'd12, 1'b0);
    @(negedge clk);
    chk("lat_n1_issue_a", alu_operand_a_o, 5);
    chk("lat_n1_wb_valid", wb_valid_o, 0);
    @(negedge clk);
    chk("lat_n2_wb_valid", wb_valid_o, 1);
    repeat (3) @(posedge clk); #1;

    // back-pressure: three requests against a stalled writeback
    wb_ready_i = 1'b0;
    send(ALU_ADD, 32'd1,  32'd2,  VEC_MODE32, 4'h1, 1'b1, 32'd3,  1'b0);
    send(ALU_ADD, 32'd10, 32'd20, VEC_MODE16, 4'h2, 1'b1, 32'd30, 1'b0);
    send(ALU_SUB, 32'd9,  32'd4,  VEC_MODE32, 4'h5, 1'b1, 32'd5,  1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_wb_valid", wb_valid_o, 1);
      chk("bp_wb_result_stable", wb_result_o, 3);
      chk("bp_req_ready_full", req_ready_o, 0);
      chk("bp_head_a", alu_operand_a_o, 10);
    end
    @(posedge clk); #1;
    wb_ready_i = 1'b1;
    repeat (6) @(posedge clk); #1;

    // slow ALU: operands hold while alu_ready_i is low
    alu_ready_i = 1'b0;
    send(ALU_ADD, 32'd100, 32'd23, VEC_MODE8, 4'h7, 1'b1, 32'd123, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("slow_alu_a", alu_operand_a_o, 100);
      chk("slow_alu_b", alu_operand_b_o, 23);
      chk("slow_alu_vm", alu_vector_mode_o, VEC_MODE8);
      chk("slow_wb_valid", wb_valid_o, 0);
    end
    chk("slow_alu_c", alu_operand_c_o, 32'hC0DE_0007);
    @(posedge clk); #1;
    alu_ready_i = 1'b1;
    @(negedge clk);
    chk("slow_capture_cycle_wbv", wb_valid_o, 0);
    @(negedge clk);
    chk("slow_after_capture_wbv", wb_valid_o, 1);
    repeat (2) @(posedge clk); #1;

    // streaming: 16 back-to-back ops
    stream_on = 1'b1;
    for (int i = 0; i < 16; i++)
      send(ALU_ADD, 32'h100 + 32'(i), 32'(i), VEC_MODE32, TAG_W'(i), 1'b1, 32'h100 + 32'(2*i), 1'b0);
    repeat (4) @(posedge clk); #1;
    stream_on = 1'b0;
    chk("stream_count", stream_seen, 16);

    // flush with wb_valid_o high, an entry queued and a coincident push
    wb_ready_i = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, VEC_MODE32, 4'h9, 1'b0, 32'd0, 1'b0);
    send(ALU_ADD, 32'd2, 32'd2, VEC_MODE32, 4'hA, 1'b0, 32'd0, 1'b0);
    req_valid_i     = 1'b1;
    req_operator_i  = ALU_ADD;
    req_operand_a_i = 32'd4;
    req_operand_b_i = 32'd4;
    req_tag_i       = 4'hB;
    flush_i         = 1'b1;
    @(negedge clk);
    chk("flush_pre_wb_valid", wb_valid_o, 1);
    @(posedge clk); #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_wb_valid", wb_valid_o, 0);
    chk("flush_busy", busy_o, 0);
    chk("flush_req_ready", req_ready_o, 1);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_issue_a", alu_operand_a_o, 0);
      chk("flush_no_wb", wb_valid_o, 0);
    end
    @(posedge clk); #1;

    // async reset while in HOLD
    wb_ready_i = 1'b0;
    send(ALU_ADD, 32'd1, 32'd2, VEC_MODE32, 4'h4, 1'b0, 32'd0, 1'b0);
    send(ALU_ADD, 32'd3, 32'd4, VEC_MODE32, 4'h6, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("hold_pre_wb_valid", wb_valid_o, 1);
    chk("hold_pre_ex_ready", alu_ex_ready_o, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    wb_ready_i = 1'b1;
    send(ALU_SUB, 32'd3, 32'd5, VEC_MODE32, 4'h2, 1'b1, 32'hFFFF_FFFE, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
